// File: rtl/gat_stage_trace_buffer.sv
// gat_stage_trace_buffer: timestamps rising edges of eight GAT stage handshake flags into a show-ahead FIFO.
//   Inputs : clk, rst, eight stage flags, arm_i/stop_i/clr_i capture control, rd_rdy_i consumer ready.
//   Outputs: rd_vld_o/rd_data_o head entry {ts, edge, flags}, count_o, full_o, drop_cnt_o, state_o.
module gat_stage_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spmm_vld_i,
    input  logic                     spmm_rdy_i,
    input  logic                     dmvm_vld_i,
    input  logic                     dmvm_rdy_i,
    input  logic                     sm_vld_i,
    input  logic                     sm_rdy_i,
    input  logic                     aggr_vld_i,
    input  logic                     aggr_rdy_i,
    input  logic                     arm_i,
    input  logic                     stop_i,
    input  logic                     clr_i,
    input  logic                     rd_rdy_i,
    output logic                     rd_vld_o,
    output logic [TS_W+15:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic [15:0]              drop_cnt_o,
    output logic [1:0]               state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = TS_W + 16;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;

    logic [1:0]     r_state;
    logic [7:0]     r_fprev;
    logic [TS_W-1:0] r_ts;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_drop;
    logic [DW-1:0]  r_mem [DEPTH];

    logic [7:0]     w_f;
    logic [7:0]     w_edge;
    logic           w_trig;
    logic           w_wr_req;
    logic           w_pop;
    logic           w_wr;
    logic           w_drop;
    logic [1:0]     w_state_nxt;
    logic [DW-1:0]  w_entry;

    assign w_f    = {spmm_vld_i, spmm_rdy_i, dmvm_vld_i, dmvm_rdy_i, sm_vld_i, sm_rdy_i, aggr_vld_i, aggr_rdy_i};
    assign w_edge = w_f & ~r_fprev;
    // stop_i outranks a trigger in WAIT; in CAPTURE the stop cycle is still recorded
    assign w_trig   = (r_state == WAIT) && w_edge[7] && !stop_i;
    assign w_wr_req = !clr_i && (w_trig || ((r_state == CAP) && (w_edge != 8'd0)));
    assign w_pop    = rd_vld_o && rd_rdy_i;
    // a pop in the same cycle frees the slot the write needs
    assign w_wr     = w_wr_req && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_drop   = w_wr_req && !w_wr;
    assign w_entry  = {(r_state == WAIT) ? {TS_W{1'b0}} : r_ts, w_edge, w_f};

    always_comb begin
        w_state_nxt = r_state;
        if (stop_i && r_state != IDLE)
            w_state_nxt = IDLE;
        else if (r_state == IDLE && arm_i)
            w_state_nxt = WAIT;
        else if (w_trig)
            w_state_nxt = CAP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_fprev  <= '0;
            r_ts     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            r_fprev <= w_f;
            if (clr_i) begin
                r_state  <= IDLE;
                r_ts     <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_drop   <= '0;
            end else begin
                r_state  <= w_state_nxt;
                r_ts     <= w_trig ? TS_W'(1) : (r_state == CAP) ? r_ts + TS_W'(1) : r_ts;
                r_wr_ptr <= r_wr_ptr + AW'(w_wr);
                r_rd_ptr <= r_rd_ptr + AW'(w_pop);
                r_count  <= r_count + CW'(w_wr) - CW'(w_pop);
                if (w_drop && r_drop != 16'hFFFF)
                    r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_entry;
    end

    assign rd_vld_o   = (r_count != '0);
    assign rd_data_o  = rd_vld_o ? r_mem[r_rd_ptr] : '0;
    assign count_o    = r_count;
    assign full_o     = (r_count == CW'(DEPTH));
    assign drop_cnt_o = r_drop;
    assign state_o    = r_state;
endmodule

// File: tb/tb_gat_stage_trace_buffer.sv
// tb_gat_stage_trace_buffer: directed checks of trigger, timestamps, overflow, pop-while-full, stop and clear.
module tb_gat_stage_trace_buffer;
    logic clk = 0;
    logic rst = 1;
    logic spmm_vld = 0, spmm_rdy = 0, dmvm_vld = 0, dmvm_rdy = 0;
    logic sm_vld = 0, sm_rdy = 0, aggr_vld = 0, aggr_rdy = 0;
    logic arm = 0, stop = 0, clr = 0, rd_rdy = 0;
    logic        rd_vld;
    logic [47:0] rd_data;
    logic [4:0]  count;
    logic        full;
    logic [15:0] drop_cnt;
    logic [1:0]  state;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [47:0] exp_q [$];

    gat_stage_trace_buffer dut (
        .clk(clk), .rst(rst),
        .spmm_vld_i(spmm_vld), .spmm_rdy_i(spmm_rdy), .dmvm_vld_i(dmvm_vld), .dmvm_rdy_i(dmvm_rdy),
        .sm_vld_i(sm_vld), .sm_rdy_i(sm_rdy), .aggr_vld_i(aggr_vld), .aggr_rdy_i(aggr_rdy),
        .arm_i(arm), .stop_i(stop), .clr_i(clr), .rd_rdy_i(rd_rdy),
        .rd_vld_o(rd_vld), .rd_data_o(rd_data), .count_o(count), .full_o(full),
        .drop_cnt_o(drop_cnt), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ent(input int ts, input logic [7:0] e, input logic [7:0] f);
        return {ts[31:0], e, f};
    endfunction

    initial begin
        tick();
        tick();
        rst = 0;
        check("rst_state", 64'(state), 0);
        check("rst_count", 64'(count), 0);
        check("rst_vld", 64'(rd_vld), 0);
        check("rst_full", 64'(full), 0);
        check("rst_drop", 64'(drop_cnt), 0);
        check("rst_data", 64'(rd_data), 0);

        arm = 1; tick(); arm = 0;
        check("arm_wait", 64'(state), 1);
        dmvm_vld = 1; tick();
        check("wait_nontrig_cnt", 64'(count), 0);
        check("wait_nontrig_st", 64'(state), 1);
        dmvm_vld = 0; tick();

        spmm_vld = 1; t0 = cyc; tick();
        check("trig_vld", 64'(rd_vld), 1);
        check("trig_state", 64'(state), 2);
        check("trig_data", 64'(rd_data), 64'(ent(0, 8'h80, 8'h80)));
        tick(); tick();
        spmm_rdy = 1; tick();
        tick(); tick(); tick();
        sm_vld = 1; aggr_rdy = 1; tick();
        check("three_cnt", 64'(count), 3);
        rd_rdy = 1;
        check("pop0", 64'(rd_data), 64'(ent(0, 8'h80, 8'h80))); tick();
        check("pop3", 64'(rd_data), 64'(ent(3, 8'h40, 8'hC0))); tick();
        check("pop7", 64'(rd_data), 64'(ent(7, 8'h09, 8'hC9))); tick();
        rd_rdy = 0;
        check("drained", 64'(rd_vld), 0);

        for (int i = 0; i < 20; i++) begin
            dmvm_rdy = 1;
            if (i < 16) exp_q.push_back(ent(cyc - t0, 8'h10, 8'hD9));
            tick();
            dmvm_rdy = 0; tick();
        end
        check("fill_cnt", 64'(count), 16);
        check("fill_full", 64'(full), 1);
        check("fill_drop", 64'(drop_cnt), 4);

        dmvm_rdy = 1; rd_rdy = 1;
        check("popfull_head", 64'(rd_data), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        exp_q.push_back(ent(cyc - t0, 8'h10, 8'hD9));
        tick();
        rd_rdy = 0; dmvm_rdy = 0;
        check("popfull_cnt", 64'(count), 16);
        check("popfull_drop", 64'(drop_cnt), 4);
        tick();
        rd_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), 64'(rd_data), 64'(exp_q[i]));
            tick();
        end
        rd_rdy = 0;
        check("drain_empty", 64'(count), 0);

        dmvm_rdy = 1; tick(); dmvm_rdy = 0; tick();
        check("pre_clr_cnt", 64'(count), 1);
        clr = 1; stop = 1; dmvm_rdy = 1; tick();
        clr = 0; stop = 0;
        check("clr_cnt", 64'(count), 0);
        check("clr_drop", 64'(drop_cnt), 0);
        check("clr_state", 64'(state), 0);
        check("clr_vld", 64'(rd_vld), 0);

        arm = 1; tick(); arm = 0;
        stop = 1; tick(); stop = 0;
        check("wait_stop", 64'(state), 0);
        {spmm_vld, spmm_rdy, dmvm_vld, dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy} = '0;
        tick();
        spmm_vld = 1; aggr_vld = 1; tick();
        check("idle_ignore_cnt", 64'(count), 0);
        check("idle_ignore_st", 64'(state), 0);

        spmm_vld = 0; tick();
        arm = 1; tick(); arm = 0;
        spmm_vld = 1; tick();
        check("rearm_cnt", 64'(count), 1);
        check("rearm_data", 64'(rd_data), 64'(ent(0, 8'h80, 8'h82)));
        rst = 1; tick(); rst = 0;
        check("midrst_cnt", 64'(count), 0);
        check("midrst_state", 64'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gat_stage_trace_buffer.md
# gat_stage_trace_buffer

Event-trace capture stage for the GAT accelerator's debug path. It sits beside the stage-flag debugger and consumes the same eight SPMM/DMVM/softmax/aggregator valid/ready flags. Each rising edge of any flag is timestamped and pushed into an on-chip FIFO, so software can reconstruct the per-stage handshake timeline. Entries are drained through a valid/ready read port.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- TS_W, 32, timestamp width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- spmm_vld_i, spmm_rdy_i, dmvm_vld_i, dmvm_rdy_i, sm_vld_i, sm_rdy_i, aggr_vld_i, aggr_rdy_i  in  1 each  stage flags
- arm_i  in  1  pulse; IDLE→WAIT
- stop_i  in  1  pulse; WAIT/CAPTURE→IDLE
- clr_i  in  1  flush FIFO and counters, go IDLE
- rd_rdy_i  in  1  consumer ready
- rd_vld_o  out  1  head entry valid
- rd_data_o  out  TS_W+16  head entry {ts, edge[7:0], flags[7:0]}
- count_o  out  $clog2(DEPTH)+1  occupancy
- full_o  out  1  count_o == DEPTH
- drop_cnt_o  out  16  events lost to full FIFO, saturating
- state_o  out  2  0 IDLE, 1 WAIT, 2 CAPTURE

## Operation
- Flag vector f = {spmm_vld, spmm_rdy, dmvm_vld, dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy}, MSB first.
- f_prev is registered every cycle in all states.
- edge = f & ~f_prev. An event occurs when edge != 0.
- FSM states:
  - IDLE: no capture. arm_i → WAIT.
  - WAIT: trigger is edge[7] (spmm_vld rising). On trigger: write entry with ts = 0, set ts counter to 1, go CAPTURE. stop_i → IDLE.
  - CAPTURE: ts increments by 1 every cycle and wraps modulo 2^TS_W. Each event writes {ts, edge, f}. stop_i → IDLE; the cycle stop_i is sampled is still captured.
  - arm_i is ignored outside IDLE. stop_i is ignored in IDLE.
- Priority: rst > clr_i > stop_i > trigger/arm.
- clr_i: empties the FIFO, zeroes drop_cnt_o and ts, and goes IDLE. f_prev still updates.
- Write acceptance: a write is accepted when count < DEPTH, or when a pop happens in the same cycle. A full FIFO with a simultaneous pop and event keeps count unchanged and stores the event.
- A rejected write increments drop_cnt_o, saturating at 0xFFFF. A rejected trigger write still moves WAIT→CAPTURE.
- Read port is show-ahead: rd_data_o is the head entry, and rd_vld_o = (count_o != 0). A pop occurs on rd_vld_o && rd_rdy_i.
- Reads are allowed in every state. The FIFO contents survive stop_i and a fresh arm_i.
- Storage is a circular buffer with wr_ptr and rd_ptr wrapping at DEPTH. The occupancy counter is separate from the pointers.

## Timing
- Reset: state IDLE; f_prev, ts, pointers, count_o, drop_cnt_o all 0; rd_vld_o 0; full_o 0; rd_data_o 0.
- Event latency: flag high in cycle N with f_prev low → entry written at the N clock edge → rd_vld_o high in N+1 if the FIFO was empty.
- arm_i in cycle N → state_o = WAIT from N+1. An edge in cycle N is not a trigger.
- Timestamps: entries in consecutive CAPTURE cycles differ by exactly 1. An event k cycles after the trigger has ts = k.
- A flag held high produces one event only. Fall followed by a re-rise produces a new event.
- Pop and write in the same cycle with count = 0: the new entry becomes visible in the next cycle; the pop is not valid this cycle.
- rst asserted mid-capture: all state is discarded the next cycle.

## Test plan
- Reset, arm, then spmm_vld_i high in cycle 5 → one entry {ts=0, edge=0x80, flags=0x80}; rd_vld_o high in cycle 6; state_o = 2.
- After trigger, spmm_rdy_i rises 3 cycles later, then sm_vld_i and aggr_rdy_i rise together 7 cycles after trigger → entries ts=3 edge=0x40, ts=7 edge=0x09.
- rd_rdy_i held 0 with DEPTH=16 and 20 distinct events → count_o = 16, full_o = 1, drop_cnt_o = 4. Drain all → the 16 oldest entries come out in order.
- Full FIFO with an event and a pop in the same cycle → count_o stays 16, drop_cnt_o unchanged, the new entry appears last.
- Event in WAIT other than spmm_vld (e.g. dmvm_vld) → no entry, state stays WAIT. stop_i → IDLE, and later edges are ignored.
- clr_i asserted during CAPTURE together with stop_i and an event → count_o = 0, drop_cnt_o = 0, state IDLE, nothing written.
